// File: rtl/progmem_loader.sv
// Program memory with a byte-serial host loader; fetch reads are combinational (0 cycles).
// The loader accepts bytes only while loading (ld_ready=1); ld_start pre-empts any byte offered with it.
module progmem_loader #(
  parameter int INST_W      = 32,
  parameter int INST_ADDR_W = 8,
  parameter int DEPTH       = 256,
  parameter int NUM_CORES   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ld_start,
  input  logic                             ld_valid,
  output logic                             ld_ready,
  input  logic [7:0]                       ld_byte,
  input  logic                             ld_last,
  output logic                             core_en,
  output logic                             ld_done,
  output logic                             err_overflow,
  output logic [INST_ADDR_W:0]             words_loaded,
  input  logic [NUM_CORES*INST_ADDR_W-1:0] progmem_addr,
  output logic [NUM_CORES*INST_W-1:0]      progmem_data
);

  localparam int LANES  = INST_W / 8;
  localparam int BIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [INST_ADDR_W:0] DEPTH_CNT = (INST_ADDR_W+1)'(DEPTH);
  localparam logic [BIDX_W-1:0]    LAST_LANE = BIDX_W'(LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BIDX_W-1:0]    r_byte_idx;
  logic [INST_W-1:0]    r_asm;
  logic [INST_W-1:0]    w_asm;
  logic [INST_ADDR_W:0] r_words;
  logic                 r_done;
  logic                 r_ovf;
  logic                 w_xfer;
  logic                 w_word_wr;
  logic                 w_full;
  logic [INST_W-1:0]    r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ld_ready    = 1'b0;
    core_en     = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ld_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        w_xfer   = ld_valid && !ld_start;
        if (w_xfer && ld_last) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        core_en = 1'b1;
        if (ld_start) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lanes above the current index are always zero, so a short final word needs no masking.
  always_comb begin
    w_asm = r_asm;
    for (int l = 0; l < LANES; l++) begin
      if (r_byte_idx == BIDX_W'(l)) w_asm[l*8 +: 8] = ld_byte;
    end
    w_word_wr = w_xfer && (ld_last || (r_byte_idx == LAST_LANE));
    w_full    = (r_words == DEPTH_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_idx <= '0;
      r_asm      <= '0;
      r_words    <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= w_xfer && ld_last;
      if (ld_start) begin
        r_byte_idx <= '0;
        r_asm      <= '0;
        r_words    <= '0;
        r_ovf      <= 1'b0;
      end else if (w_xfer) begin
        if (w_word_wr) begin
          r_byte_idx <= '0;
          r_asm      <= '0;
          if (w_full) r_ovf   <= 1'b1;
          else        r_words <= r_words + (INST_ADDR_W+1)'(1);
        end else begin
          r_byte_idx <= r_byte_idx + BIDX_W'(1);
          r_asm      <= w_asm;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_word_wr && !w_full) r_mem[r_words[MEM_AW-1:0]] <= w_asm;
  end

  assign ld_done      = r_done;
  assign err_overflow = r_ovf;
  assign words_loaded = r_words;

  // Out-of-range fetches return 0, which cores decode as a NOP.
  for (genvar c = 0; c < NUM_CORES; c++) begin : g_port
    logic [INST_ADDR_W-1:0] w_addr;
    assign w_addr = progmem_addr[c*INST_ADDR_W +: INST_ADDR_W];
    assign progmem_data[c*INST_W +: INST_W] =
      ({1'b0, w_addr} < DEPTH_CNT) ? r_mem[w_addr[MEM_AW-1:0]] : '0;
  end

endmodule

// File: tb/tb_progmem_loader.sv
// Drives a 256-word (9-bit address) instance and a 4-word instance with identical load traffic
// and checks both against a queue-based reference model, plus fixed vector tables.
module tb_progmem_loader;

  logic        clk;
  logic        rst;
  logic        ld_start, ld_valid, ld_last;
  logic [7:0]  ld_byte;
  logic        ld_ready_a, core_en_a, ld_done_a, ovf_a;
  logic        ld_ready_b, core_en_b, ld_done_b, ovf_b;
  logic [9:0]  wl_a;
  logic [3:0]  wl_b;
  logic [17:0] addr_a;
  logic [5:0]  addr_b;
  logic [63:0] data_a, data_b;

  progmem_loader #(.INST_W(32), .INST_ADDR_W(9), .DEPTH(256), .NUM_CORES(2)) dut_a (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready_a),
    .ld_byte(ld_byte), .ld_last(ld_last), .core_en(core_en_a), .ld_done(ld_done_a),
    .err_overflow(ovf_a), .words_loaded(wl_a), .progmem_addr(addr_a), .progmem_data(data_a));

  progmem_loader #(.INST_W(32), .INST_ADDR_W(3), .DEPTH(4), .NUM_CORES(2)) dut_b (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready_b),
    .ld_byte(ld_byte), .ld_last(ld_last), .core_en(core_en_b), .ld_done(ld_done_b),
    .err_overflow(ovf_b), .words_loaded(wl_b), .progmem_addr(addr_b), .progmem_data(data_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: index 0 models dut_a, index 1 models dut_b.
  localparam int DEPTH_OF [2] = '{256, 4};
  bit          m_loading, m_running, m_done;
  logic [7:0]  bq[$];
  int          m_wl  [2];
  bit          m_ovf [2];
  logic [31:0] m_mem [2][256];
  bit          m_known [2][256];

  typedef struct {
    bit         s, v;
    logic [7:0] b;
    bit         l;
    bit         e_rdy, e_en, e_done;
    int         e_wl;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 0; m_running = 0; m_done = 0;
    bq.delete();
    for (int k = 0; k < 2; k++) begin m_wl[k] = 0; m_ovf[k] = 0; end
  endtask

  task automatic model_edge(input bit s, input bit v, input logic [7:0] b, input bit l);
    logic [31:0] w;
    m_done = 0;
    if (s) begin
      m_loading = 1; m_running = 0;
      bq.delete();
      for (int k = 0; k < 2; k++) begin m_wl[k] = 0; m_ovf[k] = 0; end
    end else if (m_loading && v) begin
      bq.push_back(b);
      if (bq.size() == 4 || l) begin
        w = '0;
        foreach (bq[i]) w = w | (32'(bq[i]) << (8*i));
        for (int k = 0; k < 2; k++) begin
          if (m_wl[k] < DEPTH_OF[k]) begin
            m_mem[k][m_wl[k]]   = w;
            m_known[k][m_wl[k]] = 1;
            m_wl[k]++;
          end else m_ovf[k] = 1;
        end
        bq.delete();
        if (l) begin m_loading = 0; m_running = 1; m_done = 1; end
      end
    end
  endtask

  task automatic check_fetch();
    int a;
    for (int p = 0; p < 2; p++) begin
      a = int'(addr_a[p*9 +: 9]);
      if (a >= 256) chk("fetch_a_oob", 64'(data_a[p*32 +: 32]), 64'(0));
      else if (m_known[0][a]) chk("fetch_a", 64'(data_a[p*32 +: 32]), 64'(m_mem[0][a]));
      a = int'(addr_b[p*3 +: 3]);
      if (a >= 4) chk("fetch_b_oob", 64'(data_b[p*32 +: 32]), 64'(0));
      else if (m_known[1][a]) chk("fetch_b", 64'(data_b[p*32 +: 32]), 64'(m_mem[1][a]));
    end
  endtask

  task automatic check_status();
    chk("rdy_a", 64'(ld_ready_a), 64'(m_loading));
    chk("rdy_b", 64'(ld_ready_b), 64'(m_loading));
    chk("en_a", 64'(core_en_a), 64'(m_running));
    chk("en_b", 64'(core_en_b), 64'(m_running));
    chk("done_a", 64'(ld_done_a), 64'(m_done));
    chk("done_b", 64'(ld_done_b), 64'(m_done));
    chk("ovf_a", 64'(ovf_a), 64'(m_ovf[0]));
    chk("ovf_b", 64'(ovf_b), 64'(m_ovf[1]));
    chk("wl_a", 64'(wl_a), 64'(m_wl[0]));
    chk("wl_b", 64'(wl_b), 64'(m_wl[1]));
  endtask

  // Fetch checks happen just before the edge (read-during-write sees old data),
  // status checks 1 time unit after it.
  task automatic step(input bit s, input bit v, input logic [7:0] b, input bit l);
    ld_start = s; ld_valid = v; ld_byte = b; ld_last = l;
    for (int p = 0; p < 2; p++) begin
      addr_a[p*9 +: 9] = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
      addr_b[p*3 +: 3] = 3'($urandom_range(0, 7));
    end
    #2;
    check_fetch();
    @(posedge clk);
    model_edge(s, v, b, l);
    #1;
    check_status();
    ld_start = 0; ld_valid = 0; ld_last = 0;
  endtask

  task automatic fetch_a_const(input int p, input int addr, input logic [31:0] exp, input string name);
    @(negedge clk);
    addr_a[p*9 +: 9] = 9'(addr);
    #1;
    chk(name, 64'(data_a[p*32 +: 32]), 64'(exp));
  endtask

  task automatic load_bytes(input int n, input bit rnd, input logic [7:0] base, input bit last);
    for (int i = 0; i < n; i++)
      step(0, 1, rnd ? 8'($urandom) : base + 8'(i), last && (i == n - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] old1;
    rst = 1; ld_start = 0; ld_valid = 0; ld_last = 0; ld_byte = 0; addr_a = 0; addr_b = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    check_status();

    // Two-word image, with a byte offered in IDLE first.
    tbl[0]  = '{0, 1, 8'h55, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 8'h00, 0, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 8'h13, 0, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, 8'h00, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 1, 8'h10, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 1, 8'h00, 0, 1, 0, 0, 1};
    tbl[6]  = '{0, 1, 8'h93, 0, 1, 0, 0, 1};
    tbl[7]  = '{0, 1, 8'h00, 0, 1, 0, 0, 1};
    tbl[8]  = '{0, 1, 8'h20, 0, 1, 0, 0, 1};
    tbl[9]  = '{0, 1, 8'h00, 1, 0, 1, 1, 2};
    tbl[10] = '{0, 0, 8'h00, 0, 0, 1, 0, 2};
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].s, tbl[i].v, tbl[i].b, tbl[i].l);
      chk("tbl_rdy", 64'(ld_ready_a), 64'(tbl[i].e_rdy));
      chk("tbl_en", 64'(core_en_a), 64'(tbl[i].e_en));
      chk("tbl_done", 64'(ld_done_a), 64'(tbl[i].e_done));
      chk("tbl_wl", 64'(wl_a), 64'(tbl[i].e_wl));
    end
    fetch_a_const(0, 1, 32'h00200093, "port0_word1");
    fetch_a_const(1, 0, 32'h00100013, "port1_word0");

    // Partial final word.
    step(1, 0, 8'h00, 0);
    load_bytes(6, 0, 8'h11, 1);
    chk("partial_wl", 64'(wl_a), 64'(2));
    fetch_a_const(0, 1, 32'h00001615, "partial_word1");
    fetch_a_const(1, 0, 32'h14131211, "partial_word0");

    // Bytes offered in RUN are ignored; then a load with gaps in ld_valid.
    for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom), i == 2);
    chk("run_ignore_wl", 64'(wl_a), 64'(2));
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(0, 1, 8'hA0 + 8'(i / 2), i == 14);
      else            step(0, 0, 8'hEE, 1);
    end
    fetch_a_const(0, 0, 32'hA3A2A1A0, "bp_word0");
    fetch_a_const(1, 1, 32'hA7A6A5A4, "bp_word1");

    // 20-byte image overflows the 4-word instance only.
    step(1, 0, 8'h00, 0);
    load_bytes(20, 1, 8'h00, 1);
    chk("ovf_b_set", 64'(ovf_b), 64'(1));
    chk("ovf_b_wl", 64'(wl_b), 64'(4));
    chk("ovf_b_run", 64'(core_en_b), 64'(1));
    chk("ovf_a_clear", 64'(ovf_a), 64'(0));
    chk("ovf_a_wl", 64'(wl_a), 64'(5));

    // Reload a single word from RUN.
    old1 = m_mem[0][1];
    step(1, 0, 8'h00, 0);
    chk("reload_en_drop", 64'(core_en_a), 64'(0));
    step(0, 1, 8'hAA, 0); step(0, 1, 8'hBB, 0); step(0, 1, 8'hCC, 0); step(0, 1, 8'hDD, 1);
    fetch_a_const(0, 0, 32'hDDCCBBAA, "reload_word0");
    fetch_a_const(1, 1, old1, "reload_word1_kept");
    fetch_a_const(0, 300, 32'h0, "addr300_nop");

    // Restart mid-load, with ld_start and a valid byte in the same cycle.
    step(1, 0, 8'h00, 0);
    load_bytes(3, 1, 8'h00, 0);
    step(1, 1, 8'h77, 0);
    load_bytes(4, 1, 8'h00, 1);
    chk("restart_wl", 64'(wl_a), 64'(1));

    // Asynchronous reset between edges.
    step(1, 0, 8'h00, 0);
    load_bytes(6, 1, 8'h00, 0);
    chk("pre_rst_wl", 64'(wl_a), 64'(1));
    #2 rst = 1;
    #1;
    model_reset();
    chk("arst_en", 64'(core_en_a), 64'(0));
    chk("arst_rdy", 64'(ld_ready_a), 64'(0));
    chk("arst_wl", 64'(wl_a), 64'(0));
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    step(1, 0, 8'h00, 0);
    load_bytes(8, 1, 8'h00, 1);
    chk("post_rst_wl", 64'(wl_a), 64'(2));
    chk("post_rst_en", 64'(core_en_a), 64'(1));

    // Random traffic.
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 11) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/progmem_loader.md
Name: progmem_loader

Overview:
- Program memory that answers the core fetch interface: the core drives the instruction address and receives the instruction word back.
- Also contains a byte-serial loader. The loader fills the memory from a host and then releases the cores through a run enable.
- Sits at top level between the host load channel and the per-core fetch ports. One fetch port is provided per core.

Parameters:
- INST_W, 32, instruction width in bits; must be a multiple of 8.
- INST_ADDR_W, 8, fetch address width in words.
- DEPTH, 256, number of instruction words stored; DEPTH <= 2**INST_ADDR_W.
- NUM_CORES, 2, number of independent fetch ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ld_start  in  1  single-cycle pulse; begins a new load at word 0.
- ld_valid  in  1  host presents ld_byte.
- ld_ready  out  1  block accepts a byte; a byte transfers when ld_valid && ld_ready.
- ld_byte  in  8  load data, least-significant byte of each word first.
- ld_last  in  1  qualifies the final byte of the image; sampled only on transfer.
- core_en  out  1  run enable to all cores.
- ld_done  out  1  single-cycle pulse when a load completes.
- err_overflow  out  1  sticky flag: an image byte arrived after DEPTH words were written.
- words_loaded  out  INST_ADDR_W+1  count of words written during the current or last load.
- progmem_addr  in  NUM_CORES*INST_ADDR_W  fetch addresses, core i on slice [i*INST_ADDR_W +: INST_ADDR_W].
- progmem_data  out  NUM_CORES*INST_W  fetched instructions, same slicing as progmem_addr.

Behaviour:
- States: IDLE, LOAD, RUN.
- Reset values: state=IDLE, core_en=0, ld_ready=0, ld_done=0, err_overflow=0, words_loaded=0, byte index=0, word assembly register=0. The memory array is not reset.
- IDLE -> LOAD on ld_start.
  - On entry: words_loaded=0, byte index=0, assembly register=0, err_overflow=0.
- LOAD:
  - ld_ready=1 and core_en=0.
  - Each transfer places ld_byte into byte lane [byte index] of the assembly register, then byte index increments.
  - When byte index reaches INST_W/8-1 on a transfer, the full word is written to mem[words_loaded] on that same edge. Then words_loaded increments and byte index returns to 0.
  - ld_last on a transfer with a partial word: the remaining upper lanes are zero and the word is written immediately.
  - ld_last on a transfer: next state is RUN, with ld_done=1 for exactly one cycle, and core_en=1 from that next cycle onward.
  - Overflow: if words_loaded==DEPTH when a word would be written, the write is dropped and err_overflow is set. Bytes continue to be accepted so the host drains, and the state machine still ends on ld_last. words_loaded saturates at DEPTH and never wraps.
- RUN:
  - core_en=1 and ld_ready=0.
  - ld_start -> LOAD on the next edge; core_en drops on that same edge.
- ld_start in LOAD restarts the load: the counters clear and the partially assembled word is discarded. Memory beyond the new load point keeps its old contents.
- ld_start and a transfer in the same cycle: ld_start wins and the byte is discarded.
- Fetch read path:
  - Combinational, zero latency: progmem_data slice i = mem[progmem_addr slice i].
  - Addresses >= DEPTH return 0, the NOP encoding.
  - Ports are fully independent; simultaneous identical addresses are allowed.
- Read-during-write: a fetch of the word being written in that cycle returns the old contents. Writes become visible the next cycle.
- Asynchronous reset mid-load returns to IDLE immediately and clears all control state. Memory keeps the words already written.

Test Plan:
- Reset, then ld_start, then 8 bytes 0x13,0x00,0x10,0x00,0x93,0x00,0x20,0x00 with ld_last on the 8th -> mem[0]=0x00100013, mem[1]=0x00200093, words_loaded=2, ld_done pulses once, core_en=1 one cycle after the last transfer. Port0 address 1 reads 0x00200093 while port1 address 0 reads 0x00100013.
- Partial word: 6 bytes 0x11..0x16 with ld_last on the 6th -> mem[1]=0x00001615, words_loaded=2.
- Backpressure: ld_valid toggling every other cycle, with ld_ready forced low in IDLE/RUN -> only handshaken bytes land, and bytes offered in RUN are ignored.
- Overflow with DEPTH=4: 20 bytes with ld_last on byte 20 -> words 0..3 written, err_overflow=1, words_loaded=4, state RUN.
- Reload: in RUN, pulse ld_start -> core_en=0 next cycle. Load 4 bytes -> mem[0] updated and mem[1] unchanged. Fetch address 300 with DEPTH=256 and INST_ADDR_W=9 -> 0.
- Reset asserted asynchronously between edges after byte 2 of a load -> core_en=0, ld_ready=0, and words_loaded=0 before the next edge. A new ld_start load then works correctly.
